// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data-memory responder:
// the FSM state encoding, word/byte-enable widths and the store byte-merge helper.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Replace only the bytes selected by be; every other byte keeps its old value.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: asynchronous clear of every word,
// byte-enabled synchronous write and combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] words [DEPTH_WORDS];

  // Each word is its own register so the whole array can be cleared by reset.
  for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
    logic [WORD_W-1:0] word_reg;

    // Clear on reset; merge enabled bytes when this word is addressed.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word_reg <= '0;
      end else if (we && (waddr == AW'(gi))) begin
        word_reg <= byte_merge(word_reg, wdata, be);
      end
    end

    assign words[gi] = word_reg;
  end

  assign rdata = words[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, fixed LATENCY
// stall, then a held response. Optional address/alignment checking is
// enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              write_reg, write_next;
  logic [AW-1:0]     idx_reg, idx_next;
  logic              err_reg, err_next;
  logic [WORD_W-1:0] rdata_reg, rdata_next;
  logic              rerr_reg, rerr_next;

  logic              accept;
  logic              arr_we;
  logic              req_err;
  logic [AW-1:0]     req_idx;
  logic [WORD_W-1:0] arr_rdata;

  assign req_idx = req_addr[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH_WORDS));
`else
  // Without checking, the byte offset and upper bits are dropped (addresses wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign req_err = 1'b0;
`endif

  // Stores commit on their acceptance edge; errored stores never touch the array.
  assign arr_we = accept && req_write && !req_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (arr_we),
    .waddr(req_idx),
    .wdata(req_wdata),
    .be   (req_be),
    .raddr(idx_reg),
    .rdata(arr_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Latency counter, latched request fields and held response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
      rerr_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      write_reg <= write_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
      rerr_reg  <= rerr_next;
    end
  end

  // Next-state and handshake outputs; req_ready never looks at req_valid.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    write_next = write_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    rdata_next = rdata_reg;
    rerr_next  = rerr_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          rdata_next = (write_reg || err_reg) ? '0 : arr_rdata;
          rerr_next  = err_reg;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        req_ready  = resp_ready;
        if (resp_ready) begin
          state_next = IDLE;
          accept     = req_valid;
        end
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      state_next = BUSY;
      cnt_next   = 4'(LATENCY - 1);
      write_next = req_write;
      idx_next   = req_idx;
      err_next   = req_err;
    end
  end

  assign resp_rdata = rdata_reg;
  assign resp_err   = rerr_reg;

endmodule
